// File: rtl/line_memory_if.sv
// line_memory_if: one line-access port (request, line data, completion)
interface line_memory_if #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 4
);
  logic                         req;
  logic                         we;
  logic [ADDR_W-1:0]            addr;
  logic [LINE_WORDS*WORD_W-1:0] wdata;
  logic [LINE_WORDS-1:0]        wmask;
  logic                         ready;
  logic                         done;
  logic [LINE_WORDS*WORD_W-1:0] rdata;
  modport master (output req, we, addr, wdata, wmask, input ready, done, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output ready, done, rdata);
endinterface

// File: rtl/line_memory.sv
// line_memory: shared word memory with two independent fixed-latency line ports (i, d)
module line_memory #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input logic          clk,
  input logic          reset_n,
  line_memory_if.slave i_if,
  line_memory_if.slave d_if
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(LATENCY + 1);
  localparam int LINE_W = LINE_WORDS * WORD_W;
  typedef enum logic {IDLE, BUSY} state_t;
  logic [WORD_W-1:0]     r_mem   [DEPTH];
  state_t                r_state [2];
  logic [CW-1:0]         r_cnt   [2];
  logic [AW-1:0]         r_base  [2];
  logic                  r_we    [2];
  logic [LINE_W-1:0]     r_wdata [2];
  logic [LINE_WORDS-1:0] r_wmask [2];
  logic                  r_done  [2];
  logic [LINE_W-1:0]     r_rdata [2];
  logic                  w_req   [2];
  logic                  w_we    [2];
  logic [ADDR_W-1:0]     w_addr  [2];
  logic [LINE_W-1:0]     w_wdata [2];
  logic [LINE_WORDS-1:0] w_wmask [2];
  logic                  w_ready [2];
  logic                  w_cmp   [2];
  // index 0 is the i port, index 1 the d port; d is applied last so it wins write collisions
  assign w_req[0]   = i_if.req;
  assign w_we[0]    = i_if.we;
  assign w_addr[0]  = i_if.addr;
  assign w_wdata[0] = i_if.wdata;
  assign w_wmask[0] = i_if.wmask;
  assign w_req[1]   = d_if.req;
  assign w_we[1]    = d_if.we;
  assign w_addr[1]  = d_if.addr;
  assign w_wdata[1] = d_if.wdata;
  assign w_wmask[1] = d_if.wmask;
  assign i_if.ready = w_ready[0];
  assign i_if.done  = r_done[0];
  assign i_if.rdata = r_rdata[0];
  assign d_if.ready = w_ready[1];
  assign d_if.done  = r_done[1];
  assign d_if.rdata = r_rdata[1];
  // ready is held low during reset; completion fires when the latency count is reached
  always_comb
    for (int p = 0; p < 2; p++) begin
      w_ready[p] = reset_n && r_state[p] == IDLE;
      w_cmp[p]   = r_state[p] == BUSY && r_cnt[p] == CW'(LATENCY);
    end
  // per-port FSM: accept and latch in IDLE, count in BUSY, capture the pre-edge line on completion
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      if (!reset_n) begin
        r_state[p] <= IDLE;
        r_cnt[p]   <= '0;
        r_done[p]  <= 1'b0;
        r_rdata[p] <= '0;
      end else begin
        r_done[p] <= w_cmp[p];
        if (r_state[p] == IDLE) begin
          if (w_req[p]) begin
            r_state[p] <= BUSY;
            r_cnt[p]   <= CW'(1);
            r_base[p]  <= AW'(w_addr[p]) & ~AW'(LINE_WORDS - 1);
            r_we[p]    <= w_we[p];
            r_wdata[p] <= w_wdata[p];
            r_wmask[p] <= w_wmask[p];
          end
        end else if (w_cmp[p]) begin
          r_state[p] <= IDLE;
          r_cnt[p]   <= '0;
          for (int k = 0; k < LINE_WORDS; k++)
            r_rdata[p][(LINE_WORDS-1-k)*WORD_W +: WORD_W] <= r_mem[r_base[p] | AW'(k)];
        end else begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end
      end
  // masked line writes at completion; storage is never cleared and reset suppresses writes
  always_ff @(posedge clk)
    if (reset_n)
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < LINE_WORDS; k++)
          if (w_cmp[p] && r_we[p] && r_wmask[p][LINE_WORDS-1-k])
            r_mem[r_base[p] | AW'(k)] <= r_wdata[p][(LINE_WORDS-1-k)*WORD_W +: WORD_W];
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: randomized and directed checks of line_memory against a word-array model
module tb_line_memory;
  localparam int LAT = 4;
  typedef struct {
    logic        v;
    logic        we;
    logic [15:0] a;
    logic [63:0] wd;
    logic [3:0]  m;
  } op_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] mm [256];
  logic [63:0] exp_ri = '0;
  logic [63:0] exp_rd = '0;
  op_t nop = '{v: 1'b0, we: 1'b0, a: 16'h0, wd: 64'h0, m: 4'h0};
  line_memory_if #(.WORD_W(16), .ADDR_W(16), .LINE_WORDS(4)) ib ();
  line_memory_if #(.WORD_W(16), .ADDR_W(16), .LINE_WORDS(4)) db ();
  line_memory dut (.clk(clk), .reset_n(reset_n), .i_if(ib), .d_if(db));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int lbase(input logic [15:0] a);
    return (int'(a) % 256) / 4 * 4;
  endfunction
  function automatic logic [63:0] mread(input logic [15:0] a);
    logic [63:0] r = '0;
    for (int k = 0; k < 4; k++) r = {r[47:0], mm[lbase(a) + k]};
    return r;
  endfunction
  task automatic mwrite(input op_t o);
    for (int k = 0; k < 4; k++)
      if (o.m[3-k]) mm[lbase(o.a) + k] = o.wd[63-16*k -: 16];
  endtask
  function automatic op_t op(input logic we, input logic [15:0] a, input logic [63:0] wd, input logic [3:0] m);
    op_t o;
    o.v = 1'b1; o.we = we; o.a = a; o.wd = wd; o.m = m;
    return o;
  endfunction
  task automatic run(input op_t oi, input op_t od);
    logic [63:0] ei, ed;
    @(negedge clk);
    chk("idle_i", ib.ready, 1);
    chk("idle_d", db.ready, 1);
    ib.req = oi.v; ib.we = oi.we; ib.addr = oi.a; ib.wdata = oi.wd; ib.wmask = oi.m;
    db.req = od.v; db.we = od.we; db.addr = od.a; db.wdata = od.wd; db.wmask = od.m;
    ei = mread(oi.a);
    ed = mread(od.a);
    if (oi.v && oi.we) mwrite(oi);
    if (od.v && od.we) mwrite(od);
    @(posedge clk); #1;
    if (oi.v) begin
      chk("busy_i", ib.ready, 0);
      ib.req = 1'(($urandom) & 1); ib.we = 1'(($urandom) & 1); ib.addr = 16'($urandom);
      ib.wdata = {$urandom, $urandom}; ib.wmask = 4'($urandom);
    end
    if (od.v) begin
      chk("busy_d", db.ready, 0);
      db.req = 1'(($urandom) & 1); db.we = 1'(($urandom) & 1); db.addr = 16'($urandom);
      db.wdata = {$urandom, $urandom}; db.wmask = 4'($urandom);
    end
    for (int c = 1; c < LAT; c++) begin
      @(posedge clk); #1;
      if (oi.v) chk("early_i", ib.done, 0);
      if (od.v) chk("early_d", db.done, 0);
    end
    @(posedge clk); #1;
    chk("done_i", ib.done, oi.v);
    chk("done_d", db.done, od.v);
    if (oi.v) exp_ri = ei;
    if (od.v) exp_rd = ed;
    chk("rdata_i", ib.rdata, exp_ri);
    chk("rdata_d", db.rdata, exp_rd);
    ib.req = 1'b0;
    db.req = 1'b0;
    @(posedge clk); #1;
    chk("pulse_i", ib.done, 0);
    chk("pulse_d", db.done, 0);
    chk("rdy_i", ib.ready, 1);
    chk("rdy_d", db.ready, 1);
  endtask
  initial begin
    op_t oi, od;
    ib.req = 0; ib.we = 0; ib.addr = 0; ib.wdata = 0; ib.wmask = 0;
    db.req = 0; db.we = 0; db.addr = 0; db.wdata = 0; db.wmask = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_i", ib.ready, 0);
    chk("rst_rdy_d", db.ready, 0);
    chk("rst_done_i", ib.done, 0);
    chk("rst_done_d", db.done, 0);
    chk("rst_rd_i", ib.rdata, 0);
    chk("rst_rd_d", db.rdata, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_rdy_i", ib.ready, 1);
    chk("rel_rdy_d", db.ready, 1);
    // fill memory with word w = C3xx so later directed reads have known contents
    for (int j = 0; j < 32; j++) begin
      logic [63:0] wi, wd;
      for (int k = 0; k < 4; k++) begin
        wi[63-16*k -: 16] = 16'hC300 | 16'(8*j + k);
        wd[63-16*k -: 16] = 16'hC300 | 16'(8*j + 4 + k);
      end
      run(op(1, 16'(8*j), wi, 4'hF), op(1, 16'(8*j + 4), wd, 4'hF));
    end
    run(nop, op(1, 16'h0010, 64'h1111_2222_3333_4444, 4'hF));
    run(op(0, 16'h0012, 0, 0), nop);
    chk("r032", ib.rdata, 64'h1111_2222_3333_4444);
    run(nop, op(1, 16'h0020, 64'h0, 4'hF));
    run(nop, op(1, 16'h0020, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101));
    run(nop, op(0, 16'h0020, 0, 0));
    chk("r033", db.rdata, 64'h0000_BBBB_0000_DDDD);
    run(op(1, 16'h0030, 64'h1234_0000_0000_0000, 4'b1000), op(1, 16'h0030, 64'h5678_0000_0000_0000, 4'b1000));
    run(op(0, 16'h0030, 0, 0), nop);
    chk("r034", ib.rdata[63:48], 16'h5678);
    run(op(0, 16'h01FF, 0, 0), nop);
    chk("r037", ib.rdata, 64'hC3FC_C3FD_C3FE_C3FF);
    // reset two cycles into a d write must abort it without touching memory
    @(negedge clk);
    db.req = 1; db.we = 1; db.addr = 16'h0040; db.wdata = 64'hDEAD_BEEF_F00D_CAFE; db.wmask = 4'hF;
    @(posedge clk); #1;
    db.req = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("ar_rdy_d", db.ready, 0);
    chk("ar_rdy_i", ib.ready, 0);
    chk("ar_done_d", db.done, 0);
    chk("ar_rd_d", db.rdata, 0);
    chk("ar_rd_i", ib.rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ar_rel_d", db.ready, 1);
    exp_ri = '0;
    exp_rd = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("ar_nodone", db.done, 0);
    end
    run(nop, op(0, 16'h0040, 0, 0));
    chk("r036", db.rdata, 64'hC340_C341_C342_C343);
    // request held high: one accept every LAT+1 cycles
    @(negedge clk);
    ib.req = 1; ib.we = 0; ib.addr = 16'h0084;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      chk("hold_rdy", ib.ready, (j % 5 == 4));
      chk("hold_done", ib.done, (j % 5 == 4));
    end
    ib.req = 0;
    exp_ri = mread(16'h0084);
    chk("hold_rd", ib.rdata, exp_ri);
    for (int n = 0; n < 60; n++) begin
      oi = op(1'(($urandom) & 1), 16'($urandom), {$urandom, $urandom}, 4'($urandom));
      od = op(1'(($urandom) & 1), 16'($urandom), {$urandom, $urandom}, 4'($urandom));
      oi.v = $urandom_range(0, 3) != 0;
      od.v = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0) od.a = oi.a ^ 16'(($urandom) & 3);
      run(oi, od);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
